// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_responder data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W    = 4;
  localparam int DW_OFF_W = 3;

  // Byte-lane merge: lanes with strb set take new data, the rest keep old data.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                              input logic [63:0] new_data,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_data;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// DEPTH x 64-bit single-port storage with byte-enable write and registered read.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [63:0]              wdata_i,
  input  logic [7:0]               wstrb_i,
  output logic [63:0]              rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_d, rdata_q;

  // Contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem_q[idx_i] <= merge_bytes(mem_q[idx_i], wdata_i, wstrb_i);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) rdata_d = mem_q[idx_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port with programmable wait states.
// Optional macro DMEM_RESP_MISALIGN_ERR_EN turns addr[2:0]!=0 into an access error.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds its payload stable until that edge, and ready never depends on valid.

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;

  logic              accept, access, range_err, misalign_err, acc_err;
  logic [63:0]       arr_rdata;
  logic              unused_off;

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  // The edge that moves WAIT -> RESP is the single array access edge.
  assign access      = (state_q == WAIT) && (cnt_q == '0) && !rst_i;
  assign range_err   = |addr_q[63:IDX_W+DW_OFF_W];
`ifdef DMEM_RESP_MISALIGN_ERR_EN
  assign misalign_err = |addr_q[DW_OFF_W-1:0];
`else
  assign misalign_err = 1'b0;
`endif
  assign unused_off  = ^addr_q[DW_OFF_W-1:0];
  assign acc_err     = range_err || misalign_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = LAT_CNT;
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = acc_err;
          rd_ok_d = !write_q && !acc_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rd_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dmem_resp_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (access && !acc_err),
    .we_i    (write_q),
    .idx_i   (addr_q[IDX_W+DW_OFF_W-1:DW_OFF_W]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .rdata_o (arr_rdata)
  );

  assign resp_valid_o = (state_q == RESP);
  assign resp_err_o   = err_q;
  assign resp_rdata_o = rd_ok_q ? arr_rdata : '0;

endmodule
